// File: rtl/upd4990_if.sv
// Host-side request/response bundle for the uPD4990 serial controller.
// The master issues transactions; the controller is the slave.
interface upd4990_if;
   logic        start;
   logic [3:0]  cmd;
   logic        shift_data;
   logic [39:0] wr_data;
   logic [39:0] rd_data;
   logic        busy;
   logic        done;

   modport master (
      output start, cmd, shift_data, wr_data,
      input  rd_data, busy, done
   );

   modport slave (
      input  start, cmd, shift_data, wr_data,
      output rd_data, busy, done
   );
endinterface

// File: rtl/upd4990_ctrl.sv
// uPD4990 serial RTC controller: shifts 40 data bits plus a 4-bit
// command LSB first, strobes the chip and samples DATA_OUT on the way.
module upd4990_ctrl #(
   parameter int unsigned DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   upd4990_if.slave host,
   output logic rtc_cs_o,
   output logic rtc_clk_o,
   output logic rtc_data_o,
   output logic rtc_stb_o,
   input  logic rtc_dout_i
);

   typedef enum logic [2:0] {
      IDLE, SETUP, BIT_LO, BIT_HI, STB, HOLD, FIN
   } state_t;

   localparam logic [7:0] PH_LAST = 8'(DIV - 1);

   state_t      state_q;
   logic [7:0]  phase_q;
   logic [7:0]  phase_d;
   logic [5:0]  bit_q;
   logic        half_q;
   logic        shift_q;
   logic [43:0] sr_q;
   logic [39:0] rd_q;
   logic        busy_q;
   logic        done_q;
   logic        cs_q;
   logic        clk_q;
   logic        data_q;
   logic        stb_q;
   logic        phase_end;
   logic [5:0]  last_bit;

   assign phase_end = (phase_q == PH_LAST);
   assign phase_d   = phase_end ? 8'd0 : phase_q + 8'd1;
   assign last_bit  = shift_q ? 6'd43 : 6'd3;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         phase_q <= '0;
         bit_q   <= '0;
         half_q  <= 1'b0;
         shift_q <= 1'b0;
         sr_q    <= '0;
         rd_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cs_q    <= 1'b0;
         clk_q   <= 1'b0;
         data_q  <= 1'b0;
         stb_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (host.start) begin
                  state_q <= SETUP;
                  shift_q <= host.shift_data;
                  sr_q    <= host.shift_data ?
                             {host.cmd, host.wr_data} :
                             {40'd0, host.cmd};
                  phase_q <= '0;
                  bit_q   <= '0;
                  half_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  cs_q    <= 1'b1;
               end
            end
            SETUP: begin
               phase_q <= phase_d;
               if (phase_end) begin
                  state_q <= BIT_LO;
                  data_q  <= sr_q[0];
               end
            end
            BIT_LO: begin
               phase_q <= phase_d;
               if (phase_end) begin
                  state_q <= BIT_HI;
                  clk_q   <= 1'b1;
                  // data bits arrive LSB first; command bits are not read
                  if (shift_q && bit_q < 6'd40)
                     rd_q <= {rtc_dout_i, rd_q[39:1]};
               end
            end
            BIT_HI: begin
               phase_q <= phase_d;
               if (phase_end) begin
                  clk_q <= 1'b0;
                  if (bit_q == last_bit) begin
                     state_q <= STB;
                     data_q  <= 1'b0;
                     stb_q   <= 1'b1;
                  end else begin
                     state_q <= BIT_LO;
                     bit_q   <= bit_q + 6'd1;
                     data_q  <= sr_q[1];
                     sr_q    <= {1'b0, sr_q[43:1]};
                  end
               end
            end
            STB: begin
               phase_q <= phase_d;
               // two DIV-long halves keep the counter at 8 bits
               if (phase_end) begin
                  half_q <= ~half_q;
                  if (half_q) begin
                     state_q <= HOLD;
                     stb_q   <= 1'b0;
                  end
               end
            end
            HOLD: begin
               phase_q <= phase_d;
               if (phase_end) begin
                  state_q <= FIN;
                  cs_q    <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            FIN: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign host.rd_data = rd_q;
   assign host.busy    = busy_q;
   assign host.done    = done_q;
   assign rtc_cs_o     = cs_q;
   assign rtc_clk_o    = clk_q;
   assign rtc_data_o   = data_q;
   assign rtc_stb_o    = stb_q;

endmodule

// File: doc/upd4990_ctrl.md
UPD4990_CTRL -- requirements
Module: upd4990_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning the system-clock cycles per RTC_CLK half-period; legal range 1..255.
REQ-002 SHALL have port CLK, input, 1, system clock; every flop is updated on its rising edge.
REQ-003 SHALL have port RESET, input, 1, synchronous active-high reset sampled on the CLK rising edge.
REQ-004 SHALL have port START, input, 1, a one-cycle transaction request, accepted only in IDLE.
REQ-005 SHALL have port CMD, input, 4, the uPD4990 command code, captured when START is accepted.
REQ-006 SHALL have port SHIFT_DATA, input, 1; when high, 40 data bits are shifted before the command; captured on START.
REQ-007 SHALL have port WR_DATA, input, 40, data shifted out LSB first, captured on START.
REQ-008 SHALL have port RD_DATA, output, 40, data sampled from RTC_DOUT during the data phase.
REQ-009 SHALL have port BUSY, output, 1, high from the cycle after START is accepted until DONE.
REQ-010 SHALL have port DONE, output, 1, a one-cycle pulse when a transaction completes.
REQ-011 SHALL have ports RTC_CS, RTC_CLK, RTC_DATA and RTC_STB, each output, 1, driving the chip CS, CLK, DATA_IN and STROBE pins.
REQ-012 SHALL have port RTC_DOUT, input, 1, the chip DATA_OUT pin, synchronised externally.

Function
REQ-013 SHALL use an FSM with states IDLE, SETUP, BIT_LO, BIT_HI, STB, HOLD and FIN.
REQ-014 SHALL use an 8-bit phase counter that counts DIV cycles per state dwell; SETUP, BIT_LO, BIT_HI and HOLD each last DIV cycles, and STB lasts 2*DIV cycles.
REQ-015 SHALL move from IDLE to SETUP when START=1, latching CMD, SHIFT_DATA and WR_DATA in the same cycle; START is ignored in every other state.
REQ-016 SHALL hold RTC_CS=1 from SETUP through HOLD inclusive, and RTC_CS=0 otherwise.
REQ-017 SHALL define the bit stream as WR_DATA[0..39] followed by CMD[0..3] when SHIFT_DATA=1 (44 bits), or CMD[0..3] only when SHIFT_DATA=0 (4 bits).
REQ-018 SHALL, for each bit, hold RTC_DATA at the bit value for the whole BIT_LO+BIT_HI pair; RTC_CLK=0 in BIT_LO and RTC_CLK=1 in BIT_HI, so the chip samples on the rising edge.
REQ-019 SHALL, on the last cycle of BIT_LO for data bit i (i=0..39), store RTC_DOUT into RD_DATA[i]; RD_DATA is not written during command bits.
REQ-020 SHALL leave RD_DATA unchanged across a transaction with SHIFT_DATA=0.
REQ-021 SHALL go BIT_HI -> BIT_LO when bits remain, otherwise BIT_HI -> STB; a 6-bit bit counter tracks the bits sent.
REQ-022 SHALL drive RTC_STB=1 throughout STB with RTC_CLK=0; STB is followed by HOLD with RTC_STB=0.
REQ-023 SHALL go HOLD -> FIN -> IDLE, with DONE=1 in FIN only and BUSY=1 in every state except IDLE.
REQ-024 SHALL drive RTC_CLK=0, RTC_STB=0 and RTC_DATA=0 in IDLE, SETUP, HOLD and FIN.
REQ-025 SHALL make the latency from the START-accept cycle to the DONE cycle equal to 1 + DIV*(2 + 2*nbits + 2), giving 369 cycles for DIV=4 with 44 bits and 49 cycles for DIV=4 with 4 bits.
REQ-026 SHALL let the next START be accepted in the cycle after DONE, so back-to-back transactions are allowed.

Reset
REQ-027 SHALL, with RESET=1 at any cycle, including mid-transaction, return the FSM to IDLE and clear the counters, RD_DATA=0, BUSY=0, DONE=0, RTC_CS=0, RTC_CLK=0, RTC_DATA=0 and RTC_STB=0 on the next edge.
REQ-028 SHALL give RESET priority over a simultaneous START; that START is discarded.

Verification
REQ-029 SHALL cover reset behaviour: RESET held for 2 cycles -> all outputs 0 and RD_DATA=40'h0.
REQ-030 SHALL cover a command-only transaction: DIV=4, CMD=4'h2, SHIFT_DATA=0, START -> RTC_DATA sequence 0,1,0,0 over 4 RTC_CLK rising edges, RTC_STB high for 8 cycles, DONE 49 cycles after START is accepted, RD_DATA unchanged.
REQ-031 SHALL cover a write transaction: WR_DATA=40'h12_34_56_78_9A, CMD=4'h2, SHIFT_DATA=1 -> a chip model captures 40'h12_34_56_78_9A, then CMD 2, strobed once; DONE after 369 cycles.
REQ-032 SHALL cover a read transaction: a chip model presenting 40'hA5_5A_C3_3C_0F LSB-first, advancing on each RTC_CLK rise, SHIFT_DATA=1, CMD=4'h1 -> RD_DATA=40'hA5_5A_C3_3C_0F at DONE.
REQ-033 SHALL cover a START pulse while BUSY: START asserted mid-data-phase with a different CMD -> no effect, and the original command is sent.
REQ-034 SHALL cover reset mid-transfer: RESET during bit 20, then a new START with DIV=1, CMD=4'h3, SHIFT_DATA=0 -> outputs idle after reset, and the new transaction completes in 13 cycles.
